// File: rtl/byte_unpack_pkg.sv
// Shared definitions for the byte unpacker: FSM state encodings and the opcode field position.
// The opcode field position is common with the concatenation-side datapath.
package byte_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;

endpackage

// File: rtl/byte_unpack.sv
// Receiver-side byte unpacker: undoes the optional inversion of an incoming word and
// streams its two nibbles out over valid/ready, one per cycle, counting completed bytes.
module byte_unpack
    import byte_unpack_pkg::*;
#(
    parameter int HI_FIRST = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nib,
    output logic             out_last,
    output logic [3:0]       out_op,
    output logic [CNT_W-1:0] byte_cnt
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold;
    logic [7:0] restored;
    logic [3:0] nib_hi;
    logic [3:0] nib_lo;
    logic       accept;

    assign restored = in_data ^ {8{in_inv}};
    assign nib_hi   = hold[OP_MSB:OP_LSB];
    assign nib_lo   = hold[OP_LSB-1:0];
    assign accept   = in_valid && in_ready;

    // Stream outputs depend only on the registered state and hold; in_ready also looks at
    // out_ready so a new byte can be taken while the last nibble of the current one leaves.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_nib   = 4'h0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_FIRST;
            end
            ST_FIRST: begin
                out_valid = 1'b1;
                out_nib   = (HI_FIRST != 0) ? nib_hi : nib_lo;
                if (out_ready) state_nxt = ST_SECOND;
            end
            ST_SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_nib   = (HI_FIRST != 0) ? nib_lo : nib_hi;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? ST_FIRST : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // Inversion is undone at accept time, so in_inv only matters on the accepting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold     <= 8'h00;
            out_op   <= 4'h0;
            byte_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold   <= restored;
                out_op <= restored[OP_MSB:OP_LSB];
            end
            if (out_valid && out_ready && out_last) byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule
